// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: measures UART bit widths of a 0x55 sync character on rx
// and selects the matching baud_rate_sel code (9600..115200) for the baud
// generator. Optional build macro UART_AUTOBAUD_RETRY_EN: on error the
// detector re-arms itself up to three times before giving up.
module uart_autobaud_ctrl #(
   parameter int unsigned CLK_HZ        = 10_000_000,
   parameter int unsigned TOL_SHIFT     = 3,
   parameter int unsigned VERIFY_PULSES = 4,
   parameter int unsigned IDLE_CLKS     = 2 * CLK_HZ / 9600,
   parameter logic [2:0]  DEFAULT_SEL   = 3'b000,
   localparam int unsigned C_9600       = CLK_HZ / 9600,
   localparam int unsigned CNT_W        = $clog2(2 * C_9600) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             rx,
   output logic [2:0]       baud_rate_sel,
   output logic             locked,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] measured_clks
);

   localparam int unsigned IDLE_W = $clog2(IDLE_CLKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * C_9600);
   // one cycle before saturation: the fault registers as the counter saturates
   localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(2 * C_9600 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_IDLE, S_WAIT_FALL, S_MEASURE, S_VERIFY, S_LOCKED
   } state_t;

   // rate table, index equals the baud_rate_sel code
   function automatic int unsigned rate_hz(input int unsigned i);
      case (i)
         0:       rate_hz = 9600;
         1:       rate_hz = 19200;
         2:       rate_hz = 38400;
         3:       rate_hz = 57600;
         default: rate_hz = 115200;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic              rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [2:0]        cand_q, cand_d;
   logic [2:0]        pulse_q, pulse_d;
   logic [2:0]        sel_q, sel_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [CNT_W-1:0]  meas_q, meas_d;
`ifdef UART_AUTOBAUD_RETRY_EN
   logic [1:0]        retry_q, retry_d;
`endif

   logic       rx_edge;
   logic       timeout;
   logic [4:0] in_win;
   logic       any_win;
   logic [2:0] first_win;
   logic       fail;
   logic [1:0] fail_code;

   assign rx_edge = rx_sync_q ^ rx_prev_q;
   assign timeout = !rx_edge && (cnt_q == CNT_TMO);

   // acceptance window per rate, evaluated against the running width count
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_win
         localparam int unsigned C   = CLK_HZ / rate_hz(gi);
         localparam int unsigned TOL = C >> TOL_SHIFT;
         assign in_win[gi] = (cnt_q >= CNT_W'(C - TOL)) && (cnt_q <= CNT_W'(C + TOL));
      end
   endgenerate

   // lowest-index matching rate wins
   always_comb begin
      any_win   = 1'b0;
      first_win = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (in_win[i]) begin
            any_win   = 1'b1;
            first_win = 3'(i);
         end
      end
   end

   // next-state, width counting and output decisions
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      cand_d     = cand_q;
      pulse_d    = pulse_q;
      sel_d      = sel_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      meas_d     = meas_q;
      fail       = 1'b0;
      fail_code  = 2'd0;
`ifdef UART_AUTOBAUD_RETRY_EN
      retry_d    = retry_q;
`endif
      // width restarts at 1 on the edge cycle so the value seen at the next edge is exact
      if (rx_edge)
         cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = cnt_q;

      if (abort) begin
         if (state_q != S_LOCKED)
            state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_LOCKED: begin
               if (start) begin
                  err_code_d = 2'd0;
                  idle_cnt_d = '0;
                  state_d    = S_WAIT_IDLE;
`ifdef UART_AUTOBAUD_RETRY_EN
                  retry_d    = 2'd0;
`endif
               end
            end
            S_WAIT_IDLE: begin
               if (!rx_sync_q)
                  idle_cnt_d = '0;
               else if (idle_cnt_q == IDLE_W'(IDLE_CLKS - 1))
                  state_d = S_WAIT_FALL;
               else
                  idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
            S_WAIT_FALL: begin
               if (rx_edge && !rx_sync_q)
                  state_d = S_MEASURE;
            end
            S_MEASURE: begin
               if (rx_edge) begin
                  meas_d = cnt_q;
                  if (any_win) begin
                     cand_d  = first_win;
                     pulse_d = 3'd0;
                     state_d = S_VERIFY;
                  end else begin
                     fail      = 1'b1;
                     fail_code = 2'd1;
                  end
               end else if (timeout) begin
                  fail      = 1'b1;
                  fail_code = 2'd3;
               end
            end
            S_VERIFY: begin
               if (rx_edge) begin
                  if (!in_win[cand_q]) begin
                     fail      = 1'b1;
                     fail_code = 2'd2;
                  end else if (pulse_q == 3'(VERIFY_PULSES - 1)) begin
                     sel_d   = cand_q;
                     done_d  = 1'b1;
                     state_d = S_LOCKED;
                  end else begin
                     pulse_d = pulse_q + 3'd1;
                  end
               end else if (timeout) begin
                  fail      = 1'b1;
                  fail_code = 2'd3;
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (fail) begin
            err_d      = 1'b1;
            err_code_d = fail_code;
`ifdef UART_AUTOBAUD_RETRY_EN
            if (retry_q == 2'd3) begin
               state_d = S_IDLE;
            end else begin
               retry_d    = retry_q + 2'd1;
               idle_cnt_d = '0;
               state_d    = S_WAIT_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
      end
   end

   // state and datapath registers; synchroniser idles high so reset never fakes a fall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         cnt_q      <= '0;
         idle_cnt_q <= '0;
         cand_q     <= 3'd0;
         pulse_q    <= 3'd0;
         sel_q      <= DEFAULT_SEL;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         meas_q     <= '0;
`ifdef UART_AUTOBAUD_RETRY_EN
         retry_q    <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         cnt_q      <= cnt_d;
         idle_cnt_q <= idle_cnt_d;
         cand_q     <= cand_d;
         pulse_q    <= pulse_d;
         sel_q      <= sel_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         meas_q     <= meas_d;
`ifdef UART_AUTOBAUD_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign baud_rate_sel = sel_q;
   assign locked        = (state_q == S_LOCKED);
   assign busy          = (state_q != S_IDLE) && (state_q != S_LOCKED);
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign measured_clks = meas_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb_uart_autobaud_ctrl: directed 0x55 patterns at each rate plus boundary,
// error, abort and reset cases; done/err events are checked by a scoreboard.
`timescale 1ns/1ps
module tb_uart_autobaud_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        rx = 1'b1;
   logic [2:0]  baud_rate_sel;
   logic        locked, busy, done, err;
   logic [1:0]  err_code;
   logic [12:0] measured_clks;

   int total = 0;
   int bad   = 0;

`ifdef UART_AUTOBAUD_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      logic [2:0]  sel;
      logic [12:0] meas;
      bit          bsy;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic busy_prev = 1'b0;

   always #5 clk = ~clk;

   uart_autobaud_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .rx            (rx),
      .baud_rate_sel (baud_rate_sel),
      .locked        (locked),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .err_code      (err_code),
      .measured_clks (measured_clks)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   // start, then keep the line high long enough to pass the idle qualification
   task automatic arm();
      pulse_start();
      cyc(2150);
   endtask

   // nseg alternating segments beginning low: first lasts 'first', the rest 'w'
   task automatic send_seq(input int first, input int w, input int nseg);
      rx = 1'b0;
      cyc(first);
      for (int i = 1; i < nseg; i++) begin
         rx = ~rx;
         cyc(w);
      end
      rx = 1'b1;
      cyc(20);
   endtask

   task automatic expect_ev(input bit is_err, input logic [1:0] code, input logic [2:0] sel,
                            input logic [12:0] meas, input bit bsy);
      exp_t e;
      e.is_err = is_err;
      e.code   = code;
      e.sel    = sel;
      e.meas   = meas;
      e.bsy    = bsy;
      sb_q.push_back(e);
   endtask

   // in the retry build an error re-arms the detector; park it back in IDLE
   task automatic recover();
      if (RETRY) begin
         abort = 1'b1;
         cyc(1);
         abort = 1'b0;
         cyc(2);
      end
   endtask

   // monitor: every done/err pulse consumes one scoreboard entry
   always @(negedge clk) begin
      if (rst_n && (done || err)) begin
         check("done_err_exclusive", {31'd0, done & err}, 0);
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: done=%0b err=%0b nothing expected", done, err);
         end else begin
            mon_e = sb_q.pop_front();
            $display("event %s sel=%0d meas=%0d code=%0d busy=%0b", done ? "done" : "err",
                     baud_rate_sel, measured_clks, err_code, busy);
            check("ev_err", {31'd0, err}, {31'd0, mon_e.is_err});
            check("ev_done", {31'd0, done}, {31'd0, !mon_e.is_err});
            check("ev_sel", {29'd0, baud_rate_sel}, {29'd0, mon_e.sel});
            check("ev_locked", {31'd0, locked}, {31'd0, !mon_e.is_err});
            check("ev_meas", {19'd0, measured_clks}, {19'd0, mon_e.meas});
            check("ev_busy", {31'd0, busy}, {31'd0, mon_e.bsy});
            if (mon_e.is_err)
               check("ev_err_code", {30'd0, err_code}, {30'd0, mon_e.code});
            else
               check("busy_before_done", {31'd0, busy_prev}, 1);
         end
      end
      busy_prev = busy;
   end

   initial begin
      int n;

      // reset state
      rst_n = 1'b0;
      cyc(3);
      check("rst_sel", {29'd0, baud_rate_sel}, 0);
      check("rst_locked", {31'd0, locked}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_err_code", {30'd0, err_code}, 0);
      check("rst_meas", {19'd0, measured_clks}, 0);
      rst_n = 1'b1;
      cyc(2);

      // windows: 9600 911..1171, 19200 455..585, 38400 228..292, 57600 152..194, 115200 76..96
      arm(); expect_ev(1'b0, 2'd0, 3'd4, 13'd87, 1'b0);   send_seq(87, 87, 9);
      arm(); expect_ev(1'b0, 2'd0, 3'd0, 13'd1042, 1'b0); send_seq(1042, 1042, 9);
      arm(); expect_ev(1'b0, 2'd0, 3'd0, 13'd911, 1'b0);  send_seq(911, 911, 9);
      arm(); expect_ev(1'b0, 2'd0, 3'd1, 13'd521, 1'b0);  send_seq(521, 521, 9);
      arm(); expect_ev(1'b0, 2'd0, 3'd2, 13'd260, 1'b0);  send_seq(260, 260, 9);
      arm(); expect_ev(1'b0, 2'd0, 3'd3, 13'd174, 1'b0);  send_seq(174, 174, 9);

      // start bit one below the slowest window: code 1, rate held at 57600
      arm(); expect_ev(1'b1, 2'd1, 3'd3, 13'd910, RETRY); send_seq(910, 910, 1);
      check("err1_code_held", {30'd0, err_code}, 1);
      check("err1_locked", {31'd0, locked}, 0);
      recover();

      // 19200 start bit followed by a 38400-width pulse: code 2
      arm(); expect_ev(1'b1, 2'd2, 3'd3, 13'd520, RETRY); send_seq(520, 260, 3);
      recover();

      // line stuck low: code 3, 2 synchroniser cycles + 2082 after the drive
      arm(); expect_ev(1'b1, 2'd3, 3'd3, 13'd520, RETRY);
      rx = 1'b0;
      n = 0;
      while (!err && n < 3000) begin
         cyc(1);
         n++;
      end
      check("timeout_latency", n, 2084);
      if (n < 3000) cyc(3000 - n);
      rx = 1'b1;
      cyc(20);
      recover();

      // abort during MEASURE: idle next cycle, no events
      arm();
      rx = 1'b0;
      cyc(100);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_locked", {31'd0, locked}, 0);
      check("abort_err_code", {30'd0, err_code}, 0);
      rx = 1'b1;
      cyc(50);
      $display("abort case: busy=%0b locked=%0b", busy, locked);

      // start during VERIFY is ignored
      arm(); expect_ev(1'b0, 2'd0, 3'd2, 13'd260, 1'b0);
      fork
         send_seq(260, 260, 9);
         begin
            cyc(700);
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            check("verify_start_busy", {31'd0, busy}, 1);
         end
      join

      // reset during VERIFY
      arm();
      fork
         send_seq(174, 174, 9);
         begin
            cyc(400);
            rst_n = 1'b0;
            cyc(1);
            check("midrst_sel", {29'd0, baud_rate_sel}, 0);
            check("midrst_locked", {31'd0, locked}, 0);
            check("midrst_busy", {31'd0, busy}, 0);
            check("midrst_done", {31'd0, done}, 0);
            check("midrst_err", {31'd0, err}, 0);
            check("midrst_err_code", {30'd0, err_code}, 0);
            check("midrst_meas", {19'd0, measured_clks}, 0);
            rst_n = 1'b1;
            $display("mid-verify reset applied");
         end
      join

`ifdef UART_AUTOBAUD_RETRY_EN
      // four bad start bits in one detection: busy stays up through three retries
      pulse_start();
      cyc(2150);
      for (int k = 0; k < 4; k++) begin
         expect_ev(1'b1, 2'd1, 3'd0, 13'd300, k < 3);
         rx = 1'b0;
         cyc(300);
         rx = 1'b1;
         cyc(2150);
      end
      check("retry_exhausted_busy", {31'd0, busy}, 0);

      // bad first attempt, good second attempt locks
      arm();
      expect_ev(1'b1, 2'd1, 3'd0, 13'd300, 1'b1);
      send_seq(300, 300, 1);
      cyc(2150);
      expect_ev(1'b0, 2'd0, 3'd4, 13'd87, 1'b0);
      send_seq(87, 87, 9);
`endif

      cyc(10);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Auto-baud controller: measures incoming UART bit widths on the `rx` line and selects the matching `baud_rate_sel` code (9600/19200/38400/57600/115200).
- Sits in front of uart_baud_rate_generator and drives its `baud_rate_sel` input.
- The remote end sends sync character 0x55; the block classifies the start-bit width, confirms it against the following bit pulses, then latches and holds the rate code until the next `start`.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency; per-rate nominal bit width is C_r = CLK_HZ/rate.
- TOL_SHIFT, 3, acceptance window is C_r ± (C_r >> TOL_SHIFT).
- VERIFY_PULSES, 4, pulses after the start bit that must match; legal range 1..8.
- IDLE_CLKS, 2*CLK_HZ/9600, continuous-high time required before arming.
- DEFAULT_SEL, 3'b000, `baud_rate_sel` value after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin detection; ignored while busy
- abort  in  1  cancel detection; returns to IDLE
- rx  in  1  asynchronous UART line
- baud_rate_sel  out  3  code to the baud generator: 000=9600, 001=19200, 010=38400, 011=57600, 100=115200
- locked  out  1  high while `baud_rate_sel` is a detected, valid rate
- busy  out  1  high in any state other than IDLE/LOCKED
- done  out  1  one-cycle pulse on successful lock
- err  out  1  one-cycle pulse on failure
- err_code  out  2  1=start bit out of range, 2=verify mismatch, 3=timeout; held until next start
- measured_clks  out  CNT_W  start-bit width of the last measurement; CNT_W = $clog2(2*C_9600)+1

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - baud_rate_sel=DEFAULT_SEL; locked, busy, done, err, err_code, measured_clks = 0.
  - FSM goes to IDLE; synchroniser flops are set to 1.
- Input conditioning:
  - `rx` passes through a 2-FF synchroniser; edges are detected on the synchronised signal.
  - Width = number of clk cycles between consecutive detected edges, exact.
  - Width counter saturates at 2*C_9600.
- FSM states: IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, VERIFY, LOCKED.
- IDLE / LOCKED: on `start`, clear locked and err_code, set busy, go to WAIT_IDLE. `baud_rate_sel` keeps its previous value until a new lock.
- WAIT_IDLE: count continuous high cycles; any low resets the count. Count reaching IDLE_CLKS -> WAIT_FALL.
- WAIT_FALL: on a falling edge, clear the width counter -> MEASURE.
- MEASURE: on a rising edge:
  - Store the width in measured_clks.
  - Classify: first rate r with |width - C_r| <= C_r >> TOL_SHIFT (windows are disjoint at defaults).
  - Match -> latch candidate r, pulse counter = 0 -> VERIFY.
  - No match -> error code 1.
- VERIFY: at each edge, the pulse width must lie in r's window; the pulse counter increments.
  - Any mismatch -> error code 2.
  - Counter reaching VERIFY_PULSES -> baud_rate_sel=r, locked=1, done pulse, busy=0 -> LOCKED.
  - Remaining sync-character bits are ignored.
- Timeout: in MEASURE or VERIFY, width counter reaching 2*C_9600 without an edge -> error code 3.
- Error: err pulse for one cycle, err_code set, busy=0, locked=0, baud_rate_sel unchanged -> IDLE (see optional feature).
- abort:
  - Priority over start and over all internal transitions.
  - Forces IDLE next cycle with busy=0; no done/err pulse.
  - locked stays 0 if abort occurs mid-detection; in LOCKED, abort has no effect.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- done and err are never asserted in the same cycle; each is exactly one cycle wide.
- Latency: done is asserted 1 cycle after the synchronised edge that completes verification.

Optional Feature:
- Macro: UART_AUTOBAUD_RETRY_EN.
- Defined: on error, err still pulses and err_code is set, but the FSM re-enters WAIT_IDLE with busy=1.
  - Up to 3 retries (2-bit counter, cleared on start).
  - The 4th consecutive error -> IDLE with busy=0.
  - abort still returns to IDLE immediately.
- Undefined: every error goes straight to IDLE; the retry counter is not present.

Test Plan:
- 0x55 at 87 clk/bit after 2100 idle-high cycles, start pulsed -> done once, baud_rate_sel=100, locked=1, measured_clks=87, busy falls the cycle done rises.
- 0x55 at 1042 clk/bit -> baud_rate_sel=000, measured_clks=1042. Repeat at 521/260/174 clk/bit -> 001/010/011.
- Start bit of exactly 1041-130=911 cycles then 0x55 bits at 911 -> locks at 000. Start bit of 910 cycles -> err pulse, err_code=1, locked=0, baud_rate_sel unchanged.
- Start bit 520 cycles then a high pulse of 260 cycles -> err, err_code=2. Line held low 3000 cycles after the fall -> err_code=3 exactly 2082 cycles after the detected fall.
- abort asserted mid-MEASURE -> IDLE next cycle, no done/err, busy=0. start during VERIFY is ignored. rst_n low mid-VERIFY -> all outputs at reset values on the next cycle.
- With UART_AUTOBAUD_RETRY_EN, four bad start bits -> four err pulses, busy stays 1 through the first three, busy=0 after the fourth. A good 0x55 on the 2nd attempt -> locks.
